uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter and its dynamic-configuration port between NUM_CH AXI-Stream requesters.
- Arbitration is round-robin at packet granularity, bounded by tlast.
- Each requester carries its own 27-bit UART configuration word (same layout as the UART config port). Before granting a requester whose word differs from the one last programmed, the block drains the UART and reprograms it.
- Sits between the per-channel producers and the UART transmitter's data and config slave ports.

---
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter and its config port
module uart_tx_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BEATS = 0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_CH*16-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]    s_axis_tvalid,
  input  logic [NUM_CH-1:0]    s_axis_tlast,
  output logic [NUM_CH-1:0]    s_axis_tready,
  input  logic [NUM_CH*27-1:0] ch_cfg,
  output logic [15:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [26:0]          m_axis_config_tdata,
  output logic                 m_axis_config_tvalid,
  input  logic                 m_axis_config_tready,
  input  logic [31:0]          tx_data_count,
  output logic [2:0]           grant_id,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_CH);
  typedef enum logic [1:0] {ARB, DRAIN, CFG, PASS} state_t;
  state_t state, state_nx;
  logic [IW-1:0] g, last, pick, idx;
  logic found, beat, done, cfg_valid;
  logic [15:0] dat [NUM_CH];
  logic [26:0] cfg [NUM_CH];
  logic [26:0] cfg_lat, cur_cfg;
  logic [15:0] beats, beats_inc;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign dat[i] = s_axis_tdata[16*i +: 16];
    assign cfg[i] = ch_cfg[27*i +: 27];
  end
  // first valid channel after the last grant, wrapping around
  always_comb begin
    pick = last;
    idx = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = IW'((int'(last) + k) % NUM_CH);
      if (!found && s_axis_tvalid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign beat = state == PASS && s_axis_tvalid[g] && m_axis_tready;
  assign beats_inc = &beats ? beats : beats + 16'd1;
  assign done = s_axis_tlast[g] || (MAX_BEATS != 0 && beats_inc == 16'(MAX_BEATS));
  always_comb begin
    state_nx = state;
    case (state)
      ARB:     state_nx = !found ? ARB : (cfg_valid && cfg[pick] == cur_cfg) ? PASS : DRAIN;
      DRAIN:   state_nx = (tx_data_count == 32'd0 && m_axis_config_tready) ? CFG : DRAIN;
      CFG:     state_nx = m_axis_config_tready ? PASS : CFG;
      PASS:    state_nx = (beat && done) ? ARB : PASS;
      default: state_nx = ARB;
    endcase
    m_axis_tdata = state == PASS ? dat[g] : '0;
    m_axis_tvalid = state == PASS && s_axis_tvalid[g];
    s_axis_tready = (state == PASS && m_axis_tready) ? NUM_CH'(1) << g : '0;
    m_axis_config_tvalid = state == CFG;
    m_axis_config_tdata = state == CFG ? cfg_lat : '0;
    busy = state != ARB;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ARB;
      g <= '0;
      last <= IW'(NUM_CH - 1);
      grant_id <= '0;
      cfg_lat <= '0;
      cur_cfg <= '0;
      cfg_valid <= 1'b0;
      beats <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB && found) begin
        g <= pick;
        last <= pick;
        grant_id <= 3'(pick);
        cfg_lat <= cfg[pick];
        beats <= '0;
      end
      if (state == CFG && m_axis_config_tready) begin
        cur_cfg <= cfg_lat;
        cfg_valid <= 1'b1;
      end
      if (beat) beats <= beats_inc;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests against a packet-level model of the UART-side transaction stream
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  logic [N*16-1:0] s_axis_tdata;
  logic [N-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [N*27-1:0] ch_cfg;
  logic [15:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready;
  logic [26:0] m_axis_config_tdata;
  logic m_axis_config_tvalid, m_axis_config_tready;
  logic [31:0] tx_data_count;
  logic [2:0] grant_id;
  logic busy;

  uart_tx_arbiter #(.NUM_CH(N), .MAX_BEATS(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .ch_cfg(ch_cfg),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_config_tdata(m_axis_config_tdata), .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready),
    .tx_data_count(tx_data_count), .grant_id(grant_id), .busy(busy)
  );

  typedef struct {bit is_cfg; logic [26:0] val; int ch;} ev_t;
  ev_t exp_q[$];
  logic [16:0] pq [N][$];
  logic [16:0] mq [N][$];
  int total = 0, bad = 0, cyc = 0, cfg_cnt = 0;
  int beat_cyc[$];
  logic [26:0] last_cfg = '0;
  logic m_cfg_valid = 1'b0;
  logic [26:0] m_cfg = '0;
  logic [N-1:0] hs;
  logic prev_ok = 1'b0, prev_ctv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      s_axis_tvalid[c] = pq[c].size() > 0;
      s_axis_tdata[16*c +: 16] = pq[c].size() > 0 ? pq[c][0][15:0] : 16'h0;
      s_axis_tlast[c] = pq[c].size() > 0 && pq[c][0][16];
    end
  endtask

  task automatic send(input int c, input int n, input int base, input int inc);
    logic [16:0] v;
    for (int i = 0; i < n; i++) begin
      v = {i == n - 1, 16'(base + i * inc)};
      pq[c].push_back(v);
      mq[c].push_back(v);
    end
  endtask

  // model: a grant reprograms only when the channel's word differs from the last programmed one
  task automatic expect_grant(input int c, input int n);
    ev_t e;
    logic [16:0] b;
    if (!m_cfg_valid || m_cfg != ch_cfg[27*c +: 27]) begin
      e.is_cfg = 1'b1; e.val = ch_cfg[27*c +: 27]; e.ch = c;
      exp_q.push_back(e);
      m_cfg = ch_cfg[27*c +: 27];
      m_cfg_valid = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      b = mq[c].pop_front();
      e.is_cfg = 1'b0; e.val = 27'(b[15:0]); e.ch = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      step();
      t++;
    end
    check({name, "_done"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial forever begin
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready & {N{aresetn}};
    @(posedge aclk);
    #1;
    for (int c = 0; c < N; c++) if (hs[c]) void'(pq[c].pop_front());
    drive();
  end

  initial forever begin
    ev_t e;
    @(negedge aclk);
    cyc++;
    if (aresetn) begin
      if (m_axis_config_tvalid && !prev_ctv) check("drain_gate", 32'(prev_ok), 32'd1);
      check("tready_mask", 32'(s_axis_tready & ~(N'(1) << grant_id)), 32'd0);
      if (!busy) check("tready_idle", 32'(s_axis_tready), 32'd0);
      if (m_axis_tvalid) begin
        check("pass_data", 32'(m_axis_tdata), 32'(s_axis_tdata[16*int'(grant_id) +: 16]));
        check("pass_ready", 32'(s_axis_tready[grant_id]), 32'(m_axis_tready));
        check("no_dual_valid", 32'(m_axis_config_tvalid), 32'd0);
      end
      if (m_axis_config_tvalid && m_axis_config_tready) begin
        cfg_cnt++;
        last_cfg = m_axis_config_tdata;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cfg: got %h want none", m_axis_config_tdata);
        end else begin
          e = exp_q.pop_front();
          check("cfg_kind", 32'(e.is_cfg), 32'd1);
          check("cfg_word", 32'(m_axis_config_tdata), 32'(e.val));
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got %h want none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_kind", 32'(e.is_cfg), 32'd0);
          check("beat_data", 32'(m_axis_tdata), 32'(e.val[15:0]));
          check("beat_grant", 32'(grant_id), 32'(e.ch));
        end
      end
    end
    prev_ok = tx_data_count == 32'd0 && m_axis_config_tready;
    prev_ctv = m_axis_config_tvalid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t;
    drive();
    ch_cfg = '0;
    m_axis_tready = 1'b1;
    m_axis_config_tready = 1'b1;
    tx_data_count = 32'd0;
    repeat (3) step();
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_cfg_tvalid", 32'(m_axis_config_tvalid), 32'd0);
    check("rst_cfg_tdata", 32'(m_axis_config_tdata), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    step();

    // single packet on ch1: config first, then three beats
    ch_cfg[27*1 +: 27] = 27'h0400068;
    send(1, 3, 'h11, 'h11);
    expect_grant(1, 3);
    wait_idle("t1");
    check("t1_grant", 32'(grant_id), 32'd1);
    check("t1_cfg_cnt", 32'(cfg_cnt), 32'd1);
    check("t1_cfg_word", 32'(last_cfg), 32'h0400068);

    // ch0 and ch2 together, pointer at 1: ch2 then ch0, one config, one ARB gap
    cfg_cnt = 0;
    beat_cyc.delete();
    ch_cfg[27*0 +: 27] = 27'h0012345;
    ch_cfg[27*2 +: 27] = 27'h0012345;
    send(0, 2, 'hA0, 1);
    send(2, 2, 'hB0, 1);
    expect_grant(2, 2);
    expect_grant(0, 2);
    wait_idle("t2");
    check("t2_cfg_cnt", 32'(cfg_cnt), 32'd1);
    check("t2_beats", 32'(beat_cyc.size()), 32'd4);
    if (beat_cyc.size() == 4) check("t2_gap", 32'(beat_cyc[2] - beat_cyc[1]), 32'd2);
    check("t2_grant", 32'(grant_id), 32'd0);

    // differing config on ch3 must wait for an empty FIFO and an idle UART
    ch_cfg[27*3 +: 27] = 27'h0055AAA;
    tx_data_count = 32'd5;
    m_axis_config_tready = 1'b0;
    send(0, 2, 'hC0, 1);
    expect_grant(0, 2);
    t = 0;
    while (!m_axis_tvalid && t < 50) begin step(); t++; end
    check("t3_ch0_start", 32'(m_axis_tvalid), 32'd1);
    send(3, 2, 'hD0, 1);
    expect_grant(3, 2);
    for (int i = 0; i < 8; i++) begin step(); check("t3_hold_cnt", 32'(m_axis_config_tvalid), 32'd0); end
    tx_data_count = 32'd0;
    for (int i = 0; i < 3; i++) begin step(); check("t3_hold_rdy", 32'(m_axis_config_tvalid), 32'd0); end
    tx_data_count = 32'd2;
    m_axis_config_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); check("t3_hold_cnt2", 32'(m_axis_config_tvalid), 32'd0); end
    tx_data_count = 32'd0;
    wait_idle("t3");
    check("t3_cfg_word", 32'(last_cfg), 32'h0055AAA);

    // forced release after 4 beats lets ch1 in between ch0's chunks
    beat_cyc.delete();
    ch_cfg[27*0 +: 27] = 27'h0055AAA;
    ch_cfg[27*1 +: 27] = 27'h0055AAA;
    send(0, 10, 'h100, 1);
    send(1, 2, 'h200, 1);
    expect_grant(0, 4);
    expect_grant(1, 2);
    expect_grant(0, 4);
    expect_grant(0, 2);
    wait_idle("t4");
    check("t4_beats", 32'(beat_cyc.size()), 32'd12);

    // back-pressure toggling during a grant
    beat_cyc.delete();
    ch_cfg[27*2 +: 27] = 27'h0055AAA;
    send(2, 3, 'h300, 'h10);
    expect_grant(2, 3);
    for (int i = 0; i < 16; i++) begin
      m_axis_tready = (i % 2) == 0;
      step();
    end
    m_axis_tready = 1'b1;
    wait_idle("t5");
    check("t5_beats", 32'(beat_cyc.size()), 32'd3);

    // reset while stuck in CFG; the first grant afterwards reprograms
    ch_cfg[27*1 +: 27] = 27'h0777777;
    tx_data_count = 32'd1;
    send(1, 2, 'h400, 1);
    t = 0;
    while (!busy && t < 20) begin step(); t++; end
    check("t6_busy", 32'(busy), 32'd1);
    tx_data_count = 32'd0;
    step();
    m_axis_config_tready = 1'b0;
    step();
    check("t6_in_cfg", 32'(m_axis_config_tvalid), 32'd1);
    check("t6_cfg_word", 32'(m_axis_config_tdata), 32'h0777777);
    aresetn = 1'b0;
    step();
    check("t6_rst_cfg_tvalid", 32'(m_axis_config_tvalid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_grant", 32'(grant_id), 32'd0);
    check("t6_rst_tready", 32'(s_axis_tready), 32'd0);
    m_cfg_valid = 1'b0;
    cfg_cnt = 0;
    aresetn = 1'b1;
    m_axis_config_tready = 1'b1;
    expect_grant(1, 2);
    wait_idle("t6");
    check("t6_cfg_cnt", 32'(cfg_cnt), 32'd1);
    check("t6_grant", 32'(grant_id), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
